ib_sequencer: RTL
=================

Name: ib_sequencer

Overview:
- Control FSM that drives the 2-bit ctl code of one VECTOR-deep input buffer (0=idle/rewind, 1=store, 2=read out, 3=clear).
- Sequences clear, a handshaked load burst, then N read-out passes of the buffered vector toward the PE/MAC array.
- Flags each output beat with valid/last markers and reports completion.
- Sits between the feature-map fetch logic and the input buffer; carries no data, only control.

Parameters:
VECTOR, 4, words per buffer vector; beat counters are clog2(VECTOR+1) bits.
REPW, 8, width of the pass-count input.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin a job; sampled only in IDLE
abort  input  1  synchronous abort; wins over every other input
rep_cnt  input  REPW  number of read-out passes, captured on start; 0 is treated as 1
ld_valid  input  1  source has a load burst ready
ld_ready  output  1  a word is taken this cycle (high only in LOAD)
out_ready  input  1  consumer can take a full pass; checked in GAP
ib_ctl  output  2  buffer control code
out_valid  output  1  buffer output word valid this cycle
beat_last  output  1  with out_valid: last word of a pass
pass_last  output  1  with out_valid: word belongs to the final pass
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at job end
err  output  1  sticky: ld_valid was low during a LOAD beat; cleared on start or reset

Behaviour:
- Reset, asynchronous, and rst=0 both force IDLE with every output 0; counters and err are 0.
- ib_ctl, ld_ready, busy and done are Moore outputs decoded from the registered state.
  - IDLE=0, CLR=3, WAITL=0, LOAD=1, GAP=0, OUT=2, DONE=0.
- Buffer contract: it stores on every ctl=1 cycle. Its read data appears one cycle after each ctl=2 cycle. Any ctl=0 cycle rewinds its address.
  - Consequence: a load burst or a read pass can never stall mid-way.
- Transitions:
  - IDLE: start -> CLR. Capture rep_cnt (0 becomes 1) and clear err.
  - CLR: 1 cycle -> WAITL.
  - WAITL: ld_valid=1 -> LOAD; otherwise stay.
  - LOAD: exactly VECTOR cycles with ld_ready=1; beat counter 0..VECTOR-1. Last beat -> GAP.
    - Source contract: VECTOR consecutive valid words once LOAD is entered.
    - ld_valid=0 on any LOAD beat sets err. The beat still completes, and the buffer stores whatever is on its input.
  - GAP: 1 or more cycles at ctl=0. out_ready=1 -> OUT; otherwise stay.
  - OUT: exactly VECTOR cycles; beat counter 0..VECTOR-1; on the last beat the pass counter increments.
    - Passes remaining -> GAP.
    - Final pass -> DONE.
  - DONE: 1 cycle, done=1 -> IDLE.
- Output flags:
  - out_valid is (state==OUT) registered one cycle, so it aligns with buffer data.
  - beat_last and pass_last are registered the same way from the beat and pass counters.
  - The final out_valid beat coincides with the DONE cycle.
- abort in any non-IDLE state: next state CLR (buffer cleared), then WAITL is bypassed and the FSM returns to IDLE.
  - The pending out_valid pipeline bit is flushed. Registered flags are zero from the next cycle.
  - No done pulse.
- abort in IDLE does nothing.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins, start is ignored.
- Latency for VECTOR=4, rep_cnt=1, with start seen at edge 0 and ld_valid/out_ready held high:
  - CLR c1, WAITL c2, LOAD c3-c6, GAP c7, OUT c8-c11.
  - out_valid c9-c12, DONE c12, IDLE c13.
- Each extra pass adds 5 cycles (1 GAP + VECTOR OUT). rep_cnt=255 gives 255 passes with no counter wrap.

Test Plan:
- Reset mid-LOAD at beat 2: rst low -> ib_ctl=0, ld_ready=0, busy=0 immediately (async). After release, state is IDLE and err=0.
- VECTOR=4, rep_cnt=1, ld_valid and out_ready tied high, start pulse at c0 -> ib_ctl sequence 3,0,1,1,1,1,0,2,2,2,2,0 over c1-c12. out_valid c9-c12, beat_last c12, pass_last c9-c12, done c12 only.
- rep_cnt=3, out_ready low for 5 cycles in the second GAP -> ib_ctl holds 0 for those cycles. 12 out_valid beats total, beat_last every 4th, pass_last only on beats 9-12, one done.
- rep_cnt=0 -> behaves as 1 pass (4 out_valid beats, one done).
- ld_valid drops on LOAD beat 2 -> LOAD still lasts 4 cycles and err=1 stays set through DONE. The next start clears err.
- abort on the second OUT beat -> next cycle ib_ctl=3, then IDLE. out_valid drops to 0 by the cycle after the CLR cycle, no done. A start issued while busy in a separate run is ignored.

Source files
------------

// File: rtl/ib_sequencer.sv
// ---------------------------------------------------------------------------
// ib_sequencer
//
// Control FSM for one VECTOR-deep input buffer feeding the PE/MAC array.
// A job clears the buffer, takes one handshaked load burst of VECTOR words,
// then replays the stored vector rep_cnt times (0 counts as 1). Each replay
// is preceded by a GAP cycle in which the consumer must show out_ready. The
// block carries no data: it only drives the buffer's 2-bit control code and
// marks each output word with valid/last flags.
//
// Buffer control code (ib_ctl):
//   0 = idle / rewind address, 1 = store, 2 = read out, 3 = clear
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      begin a job (sampled only in IDLE)
//   abort      synchronous abort, wins over every other input
//   rep_cnt    number of read-out passes, captured on start
//   ld_valid   source has a load word ready
//   ld_ready   a word is taken this cycle (LOAD only)
//   out_ready  consumer can accept a full pass (checked in GAP)
//   ib_ctl     buffer control code
//   out_valid  buffer output word valid this cycle
//   beat_last  with out_valid: last word of a pass
//   pass_last  with out_valid: word belongs to the final pass
//   busy       high in every state except IDLE
//   done       one-cycle pulse at job end
//   err        sticky load-protocol error, cleared on start or reset
// ---------------------------------------------------------------------------
module ib_sequencer #(
  parameter int VECTOR = 4,
  parameter int REPW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [REPW-1:0] rep_cnt,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            out_ready,
  output logic [1:0]      ib_ctl,
  output logic            out_valid,
  output logic            beat_last,
  output logic            pass_last,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int BW = $clog2(VECTOR + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(VECTOR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAITL,
    S_LOAD,
    S_GAP,
    S_OUT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CTL_REWIND = 2'd0,
    CTL_STORE  = 2'd1,
    CTL_READ   = 2'd2,
    CTL_CLEAR  = 2'd3
  } ctl_t;

  state_t          state, state_nx;
  logic [BW-1:0]   beat, beat_nx;
  logic [REPW-1:0] pass, pass_nx;
  logic [REPW-1:0] reps, reps_nx;
  logic            abort_pend, abort_pend_nx;
  logic            err_nx;

  logic beat_end;
  logic final_pass;
  logic flag_en;

  // reps is never 0 while busy, so reps-1 is the index of the final pass and
  // pass never has to reach a value past reps (no wrap at the REPW limit).
  assign beat_end   = (beat == LAST_BEAT);
  assign final_pass = (pass == reps - REPW'(1));

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      beat       <= '0;
      pass       <= '0;
      reps       <= '0;
      abort_pend <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      beat       <= beat_nx;
      pass       <= pass_nx;
      reps       <= reps_nx;
      abort_pend <= abort_pend_nx;
      err        <= err_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable is given its hold value first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx      = state;
    beat_nx       = beat;
    pass_nx       = pass;
    reps_nx       = reps;
    abort_pend_nx = abort_pend;
    err_nx        = err;

    if (state == S_IDLE) begin
      // abort in IDLE has no effect of its own but still suppresses start.
      if (start && !abort) begin
        state_nx      = S_CLR;
        reps_nx       = (rep_cnt == '0) ? REPW'(1) : rep_cnt;
        pass_nx       = '0;
        beat_nx       = '0;
        err_nx        = 1'b0;
        abort_pend_nx = 1'b0;
      end
    end else if (abort) begin
      // Clear the buffer once, then fall back to IDLE from CLR.
      state_nx      = S_CLR;
      abort_pend_nx = 1'b1;
      beat_nx       = '0;
    end else begin
      case (state)
        S_CLR: begin
          state_nx      = abort_pend ? S_IDLE : S_WAITL;
          abort_pend_nx = 1'b0;
        end

        S_WAITL: begin
          if (ld_valid) begin
            state_nx = S_LOAD;
            beat_nx  = '0;
          end
        end

        S_LOAD: begin
          // The buffer stores on every ctl=1 cycle, so the burst cannot
          // stall; a missing word is only reported.
          if (!ld_valid) begin
            err_nx = 1'b1;
          end
          if (beat_end) begin
            beat_nx  = '0;
            state_nx = S_GAP;
          end else begin
            beat_nx = beat + 1'b1;
          end
        end

        S_GAP: begin
          if (out_ready) begin
            state_nx = S_OUT;
          end
        end

        S_OUT: begin
          if (beat_end) begin
            beat_nx  = '0;
            pass_nx  = pass + 1'b1;
            state_nx = final_pass ? S_DONE : S_GAP;
          end else begin
            beat_nx = beat + 1'b1;
          end
        end

        S_DONE: begin
          state_nx = S_IDLE;
        end

        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs decoded from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    ib_ctl   = CTL_REWIND;
    ld_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_CLR:  ib_ctl = CTL_CLEAR;
      S_LOAD: begin
        ib_ctl   = CTL_STORE;
        ld_ready = 1'b1;
      end
      S_OUT:  ib_ctl = CTL_READ;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output word flags
  // ---------------------------------------------------------------------------
  // Buffer read data lags each ctl=2 cycle by one clock, so the flags are the
  // OUT-state decode delayed by one register. An abort in the OUT cycle
  // flushes the bit that would otherwise still be in flight.
  assign flag_en = (state == S_OUT) && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      beat_last <= 1'b0;
      pass_last <= 1'b0;
    end else begin
      out_valid <= flag_en;
      beat_last <= flag_en && beat_end;
      pass_last <= flag_en && final_pass;
    end
  end

endmodule
